// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one 12-bit ALU between the
//                fetch/PC-update requester (port 0) and the execute
//                requester (port 1); one operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter #(
    parameter int DW  = 12,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_opcode,
    input  logic [DW-1:0]  req0_op1,
    input  logic [DW-1:0]  req0_op2,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_opcode,
    input  logic [DW-1:0]  req1_op1,
    input  logic [DW-1:0]  req1_op2,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp_data,

    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_op1,
    output logic [DW-1:0]  alu_op2,
    input  logic [DW-1:0]  alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_prio;
    logic           r_owner;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;
    logic [DW-1:0]  r_rsp_data;
    logic [OPW-1:0] r_alu_opcode;
    logic [DW-1:0]  r_alu_op1;
    logic [DW-1:0]  r_alu_op2;

    logic           w_idle;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_rsp_taken;

    // r_prio names the port favoured on a tie: it resets to 0 and flips to
    // the loser after every grant, giving strict alternation under contention.
    assign w_gnt0 = req0_valid && (!req1_valid || !r_prio);
    assign w_gnt1 = req1_valid && (!req0_valid ||  r_prio);

    // rst_n gating keeps ready low while reset is held, not only after it.
    assign w_idle      = (r_state == IDLE) && rst_n;
    assign req0_ready  = w_idle && w_gnt0;
    assign req1_ready  = w_idle && w_gnt1;
    assign w_rsp_taken = r_owner ? rsp1_ready : rsp0_ready;

    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp_data    = r_rsp_data;
    assign alu_opcode  = r_alu_opcode;
    assign alu_op1     = r_alu_op1;
    assign alu_op2     = r_alu_op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0) begin
                        r_alu_opcode <= req0_opcode;
                        r_alu_op1    <= req0_op1;
                        r_alu_op2    <= req0_op2;
                        r_owner      <= 1'b0;
                        r_prio       <= 1'b1;
                        r_state      <= EXEC;
                    end else if (w_gnt1) begin
                        r_alu_opcode <= req1_opcode;
                        r_alu_op1    <= req1_op1;
                        r_alu_op2    <= req1_op2;
                        r_owner      <= 1'b1;
                        r_prio       <= 1'b0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data <= alu_out;
                    if (r_owner) begin
                        r_rsp1_valid <= 1'b1;
                    end else begin
                        r_rsp0_valid <= 1'b1;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (w_rsp_taken) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a transaction-level
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;

    localparam int DW  = 12;
    localparam int OPW = 3;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0] req0_opcode, req1_opcode;
    logic [DW-1:0]  req0_op1, req0_op2, req1_op1, req1_op2;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0]  rsp_data;
    logic [OPW-1:0] alu_opcode;
    logic [DW-1:0]  alu_op1, alu_op2, alu_out;

    int n_chk  = 0;
    int n_pass = 0;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_opcode(req0_opcode),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_opcode(req1_opcode),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_data   (rsp_data),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: any deterministic function of opcode and operands works.
    function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] o,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (o)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = ~(a & b);
            3'd6:    alu_f = a << 1;
            default: alu_f = a >> 1;
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_op1, alu_op2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction model: one op in flight; phase 0 = ALU being driven, 1 = response offered.
    logic           m_busy, m_phase, m_owner, m_next;
    logic [OPW-1:0] m_opc;
    logic [DW-1:0]  m_a, m_b, m_data;
    logic           m_g0, m_g1;

    assign m_g0 = req0_valid && (!req1_valid || m_next == 1'b0);
    assign m_g1 = req1_valid && (!req0_valid || m_next == 1'b1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_phase <= 1'b0; m_owner <= 1'b0; m_next <= 1'b0;
            m_opc  <= '0;   m_a     <= '0;   m_b     <= '0;   m_data <= '0;
        end else if (!m_busy) begin
            if (m_g0 || m_g1) begin
                m_busy  <= 1'b1;
                m_phase <= 1'b0;
                m_owner <= m_g1;
                m_next  <= !m_g1;
                m_opc   <= m_g1 ? req1_opcode : req0_opcode;
                m_a     <= m_g1 ? req1_op1    : req0_op1;
                m_b     <= m_g1 ? req1_op2    : req0_op2;
            end
        end else if (!m_phase) begin
            m_phase <= 1'b1;
            m_data  <= alu_f(m_opc, m_a, m_b);
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy <= 1'b0;
        end
    end

    int          gq[$];
    logic [DW-1:0] rd0[$], rd1[$];

    always @(negedge clk) begin
        chk("req0_ready", req0_ready, rst_n && !m_busy && m_g0);
        chk("req1_ready", req1_ready, rst_n && !m_busy && m_g1);
        chk("rsp0_valid", rsp0_valid, m_busy && m_phase && !m_owner);
        chk("rsp1_valid", rsp1_valid, m_busy && m_phase &&  m_owner);
        chk("rsp_data",   rsp_data,   m_data);
        chk("alu_opcode", alu_opcode, m_opc);
        chk("alu_op1",    alu_op1,    m_a);
        chk("alu_op2",    alu_op2,    m_b);
        if (req0_valid && req0_ready) gq.push_back(0);
        if (req1_valid && req1_ready) gq.push_back(1);
        if (rsp0_valid && rsp0_ready) rd0.push_back(rsp_data);
        if (rsp1_valid && rsp1_ready) rd1.push_back(rsp_data);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [DW-1:0] bnd [8];

    initial begin
        bnd = '{12'hFFE, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFE, 12'h7FF};
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_opcode = '0; req0_op1 = '0; req0_op2 = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_op1 = '0; req1_op2 = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) step();
        chk("reset_rsp_data", rsp_data, 12'h000);
        chk("reset_alu_op1", alu_op1, 12'h000);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        rst_n = 1'b1;

        // Single op on port 0
        req0_valid = 1'b1; req0_opcode = 3'd5; req0_op1 = 12'h0F0; req0_op2 = 12'h00F;
        #1 chk("single_req0_ready", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        #1;
        chk("single_alu_opcode", alu_opcode, 3'd5);
        chk("single_alu_op1", alu_op1, 12'h0F0);
        chk("single_alu_op2", alu_op2, 12'h00F);
        chk("single_rsp0_early", rsp0_valid, 1'b0);
        step(); #1;
        chk("single_rsp0_valid", rsp0_valid, 1'b1);
        chk("single_rsp_data", rsp_data, 12'hFFF);
        chk("single_rsp1_valid", rsp1_valid, 1'b0);
        step();

        // Contention from a fresh reset: grants must go 0,1,0,1
        rst_n = 1'b0; step(); rst_n = 1'b1;
        gq.delete(); rd0.delete(); rd1.delete();
        req0_valid = 1'b1; req0_opcode = 3'd0; req0_op1 = 12'h001; req0_op2 = 12'h002;
        req1_valid = 1'b1; req1_opcode = 3'd0; req1_op1 = 12'h7FF; req1_op2 = 12'h800;
        repeat (12) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_grants", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("cont_g0", gq[0], 0);
            chk("cont_g1", gq[1], 1);
            chk("cont_g2", gq[2], 0);
            chk("cont_g3", gq[3], 1);
        end
        chk("cont_rsp0_count", rd0.size(), 2);
        chk("cont_rsp1_count", rd1.size(), 2);
        if (rd0.size() > 0) chk("cont_rsp0_data", rd0[0], 12'h003);
        if (rd1.size() > 0) chk("cont_rsp1_data", rd1[0], 12'hFFF);

        // Backpressure on port 1 with port 0 waiting
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_opcode = 3'd4; req1_op1 = 12'h0A5; req1_op2 = 12'h05A;
        step(); req1_valid = 1'b0;
        req0_valid = 1'b1; req0_opcode = 3'd1; req0_op1 = 12'h300; req0_op2 = 12'h100;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp1_valid", rsp1_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 12'h0FF);
            chk("bp_req0_ready", req0_ready, 1'b0);
            step();
        end
        rsp1_ready = 1'b1;
        step(); #1;
        chk("bp_req0_granted", req0_ready, 1'b1);
        step(); req0_valid = 1'b0;
        step(); #1;
        chk("bp_rsp0_valid", rsp0_valid, 1'b1);
        chk("bp_rsp0_data", rsp_data, 12'h200);
        step();

        // All-ones operands through every opcode on port 1
        for (int op = 0; op < 8; op++) begin
            req1_valid = 1'b1; req1_opcode = OPW'(op); req1_op1 = 12'hFFF; req1_op2 = 12'hFFF;
            step(); req1_valid = 1'b0;
            step(); #1;
            chk("bnd_rsp1_valid", rsp1_valid, 1'b1);
            chk("bnd_rsp_data", rsp_data, bnd[op]);
            chk("bnd_no_x", 32'($isunknown({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                                             rsp_data, alu_opcode, alu_op1, alu_op2})), 0);
            step();
        end

        // Asynchronous reset while the ALU is being driven
        req0_valid = 1'b1; req0_opcode = 3'd3; req0_op1 = 12'h123; req0_op2 = 12'h456;
        step(); req0_valid = 1'b0;
        req1_valid = 1'b1; req1_opcode = 3'd2; req1_op1 = 12'h0F0; req1_op2 = 12'h0FF;
        #1 chk("rst_exec_alu_op1", alu_op1, 12'h123);
        rst_n = 1'b0;
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 12'h000);
        chk("rst_alu_op1", alu_op1, 12'h000);
        chk("rst_alu_opcode", alu_opcode, 3'd0);
        step(); rst_n = 1'b1;
        #1 chk("rst_req1_ready", req1_ready, 1'b1);
        step(); req1_valid = 1'b0;
        step(); #1;
        chk("rst_rsp1_valid", rsp1_valid, 1'b1);
        chk("rst_rsp1_data", rsp_data, 12'h0F0);
        chk("rst_rsp0_quiet", rsp0_valid, 1'b0);
        step();

        // Idle hold: drive registers keep the last operands
        repeat (10) step();
        #1;
        chk("idle_alu_opcode", alu_opcode, 3'd2);
        chk("idle_alu_op1", alu_op1, 12'h0F0);
        chk("idle_alu_op2", alu_op2, 12'h0FF);
        chk("idle_req1_ready", req1_ready, 1'b0);
        chk("idle_rsp1_valid", rsp1_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
